// File: rtl/wide_to_narrow_serializer.sv
// Splits each WIDTH_IN-bit word from an upstream FIFO into WIDTH_IN/WIDTH_OUT beats
// on a valid/ready output, with zero-bubble reload of the next word on the last beat.
module wide_to_narrow_serializer #(
  parameter int unsigned WIDTH_IN  = 32,
  parameter int unsigned WIDTH_OUT = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH_IN-1:0]  data_i,
  input  logic                 v_i,
  output logic                 yumi_o,
  output logic [WIDTH_OUT-1:0] data_o,
  output logic                 v_o,
  output logic                 last_o,
  input  logic                 ready_i
);

  localparam int unsigned N    = WIDTH_IN / WIDTH_OUT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

  if ((WIDTH_OUT == 0) || (WIDTH_IN % WIDTH_OUT != 0) || (N < 2)) begin : g_bad_params
    $error("wide_to_narrow_serializer: WIDTH_IN must be a multiple >= 2 of WIDTH_OUT");
  end

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH_IN-1:0] hold_q;

  logic            at_last;
  logic [CntW-1:0] sel;

  assign at_last = (cnt_q == CntMax);

  // Reload on the final beat only when it actually transfers; never during reset.
  assign yumi_o = ~reset_i & v_i & ((state_q == StIdle) | (ready_i & at_last));

  assign v_o    = (state_q == StBusy);
  assign last_o = v_o & at_last;
  assign sel    = LSB_FIRST ? cnt_q : (CntMax - cnt_q);

  always_comb begin
    data_o = '0;
    if (v_o) begin
      for (int i = 0; i < int'(N); i++) begin
        if (sel == CntW'(i)) data_o = hold_q[i*WIDTH_OUT +: WIDTH_OUT];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else if (yumi_o) begin
      state_q <= StBusy;
      cnt_q   <= '0;
      hold_q  <= data_i;
    end else if ((state_q == StBusy) && ready_i) begin
      if (at_last) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/wide_to_narrow_serializer.md
WIDE_TO_NARROW_SERIALIZER -- requirements
Module: wide_to_narrow_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH_IN, default 32, the width of the consumed word.
REQ-002 The block SHALL have parameter WIDTH_OUT, default 8, the width of each emitted beat.
REQ-003 The block SHALL have parameter LSB_FIRST, default 1: 1 emits the low slice first, 0 emits the high slice first.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1, reset that is synchronous and active-high.
REQ-006 The block SHALL have port data_i, input, WIDTH_IN, the word offered by the upstream FIFO.
REQ-007 The block SHALL have port v_i, input, 1, meaning upstream data_i is valid.
REQ-008 The block SHALL have port yumi_o, output, 1, meaning the word on data_i is consumed this cycle.
REQ-009 The block SHALL have port data_o, output, WIDTH_OUT, the current beat.
REQ-010 The block SHALL have port v_o, output, 1, meaning data_o is valid.
REQ-011 The block SHALL have port last_o, output, 1, meaning the current beat is the final slice of its word.
REQ-012 The block SHALL have port ready_i, input, 1, meaning downstream accepts the beat this cycle.

Function
REQ-013 WIDTH_IN SHALL be an integer multiple of WIDTH_OUT, with N = WIDTH_IN/WIDTH_OUT >= 2; other values are illegal and SHALL stop elaboration.
REQ-014 The block SHALL have a two-state FSM: IDLE (no word held) and BUSY (word held; beats pending).
REQ-015 The block SHALL have a beat counter cnt of width clog2(N), counting 0..N-1.
REQ-016 yumi_o SHALL equal v_i & (IDLE | (BUSY & ready_i & cnt==N-1)); it is combinational and never asserts when v_i=0.
REQ-017 On yumi_o=1, data_i SHALL be captured into the holding register, the FSM SHALL enter or stay in BUSY, and cnt SHALL clear to 0.
REQ-018 In BUSY, v_o SHALL be 1; in IDLE, v_o SHALL be 0.
REQ-019 data_o SHALL be slice cnt of the held word: bits [cnt*WIDTH_OUT +: WIDTH_OUT] if LSB_FIRST=1, otherwise slice N-1-cnt.
REQ-020 last_o SHALL equal v_o & (cnt==N-1).
REQ-021 A beat transfers when v_o & ready_i; on a transfer with cnt<N-1, cnt SHALL increment by 1.
REQ-022 On a transfer with cnt==N-1 and v_i=0, the FSM SHALL return to IDLE and cnt SHALL clear to 0.
REQ-023 On a transfer with cnt==N-1 and v_i=1, the next word SHALL load in the same cycle with no bubble.
REQ-024 While v_o=1 and ready_i=0, data_o, last_o and cnt SHALL hold stable (no retraction), and yumi_o SHALL be 0.
REQ-025 Latency SHALL be 1 cycle: a word consumed in cycle t presents its first beat in cycle t+1.
REQ-026 Sustained throughput SHALL be one beat per cycle when v_i and ready_i are held high.
REQ-027 The block SHALL NOT inspect or depend on v_i beyond REQ-016; data_i is sampled only when yumi_o=1.

Reset
REQ-028 While reset_i=1 at a clock edge, the FSM SHALL go to IDLE, cnt to 0, and the holding register to 0.
REQ-029 During and after reset, v_o, last_o and yumi_o SHALL be 0, and data_o SHALL be 0.
REQ-030 Reset asserted mid-word SHALL discard remaining beats; the first word after reset SHALL start at slice 0.

Verification
REQ-031 Scenario: reset, v_i=1, data_i=32'hDDCCBBAA, ready_i=1 -> yumi_o=1 in cycle 0; beats AA,BB,CC,DD in cycles 1-4; last_o=1 only in cycle 4; v_o=0 in cycle 5.
REQ-032 Scenario: back-to-back words 32'h03020100 and 32'h07060504 with ready_i=1 -> 8 consecutive beats 00..07 with no gap; yumi_o pulses in cycles 0 and 4.
REQ-033 Scenario: ready_i=0 for 3 cycles at beat BB -> data_o=BB, v_o=1 held for 3 cycles; yumi_o=0 throughout; order is unchanged afterward.
REQ-034 Scenario: LSB_FIRST=0, data_i=32'h11223344 -> beats 11,22,33,44.
REQ-035 Scenario: reset_i=1 after beat BB transfers -> next cycle v_o=0; new word 32'h0000EE55 emits 55 first.
REQ-036 Scenario: v_i=0 for 10 cycles while IDLE -> yumi_o=0 and v_o=0 throughout.
